// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined divider.
//   div_flags_t     : per-stage control payload (sign fix-ups, divide-by-zero, valid)
//   DIV_ALL_ONES    : quotient pattern reported for a divide by zero (slice to WIDTH)
//   div_operand_neg : decides whether an operand is converted to its magnitude
// Data fields of the stage payload (rem, dvd_rest, dvs, q) depend on WIDTH and
// therefore live as parallel per-stage arrays inside divider_pipe_n.
package divider_pkg;

    localparam int DIV_MAX_W = 64;
    localparam logic [DIV_MAX_W-1:0] DIV_ALL_ONES = '1;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic dbz;
        logic valid;
    } div_flags_t;

    function automatic logic div_operand_neg(input logic signed_mode, input logic sign_bit);
        return signed_mode & sign_bit;
    endfunction

endpackage

// File: rtl/div_stage.sv
// One pipeline stage of the array divider: BITS_PER_STAGE non-restoring rows,
// purely combinational.
//   rem_i/rem_o : partial remainder, WIDTH+1 bits, two's complement
//   dvd_i/dvd_o : dividend bits not yet consumed, MSB first
//   dvs_i       : divisor magnitude
//   quo_i/quo_o : quotient bits resolved so far, shifted in at the LSB
module div_stage #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic [WIDTH-1:0] quo_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dvd_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   rem_row;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] dvd_row;
    logic [WIDTH-1:0] quo_row;

    always_comb begin
        rem_row   = rem_i;
        dvd_row   = dvd_i;
        quo_row   = quo_i;
        rem_shift = '0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            // 2R + next dividend bit; |R| < divisor keeps the result inside WIDTH+1 bits
            rem_shift = {rem_row[WIDTH-1:0], dvd_row[WIDTH-1]};
            // A negative remainder means the previous quotient bit was 0: add this row
            if (rem_row[WIDTH]) begin
                rem_row = rem_shift + {1'b0, dvs_i};
            end else begin
                rem_row = rem_shift - {1'b0, dvs_i};
            end
            dvd_row = {dvd_row[WIDTH-2:0], 1'b0};
            quo_row = {quo_row[WIDTH-2:0], ~rem_row[WIDTH]};
        end
        rem_o = rem_row;
        dvd_o = dvd_row;
        quo_o = quo_row;
    end

endmodule

// File: rtl/divider_pipe_n.sv
// Fully pipelined integer divider, one divide accepted per cycle, results in order.
// Register 0 captures operand magnitudes; each of STAGES div_stage blocks then
// resolves BITS_PER_STAGE quotient bits. The last block also performs the
// remainder-restore add and sign fix-up in front of the output register, so
// a result appears STAGES edges after its accept edge.
// Ports:
//   clk, reset (async, active high)
//   in_valid/in_ready, in_signed, in_dividend, in_divisor   : operand side
//   out_valid/out_ready, out_quotient, out_remainder,
//   out_div_by_zero                                         : result side
// Build option: DIVIDER_SIGNED_EN enables two's-complement mode via in_signed;
// without it every divide is unsigned and in_signed is ignored.
module divider_pipe_n
    import divider_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero
);

    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int LAST   = STAGES - 1;

    logic [WIDTH:0]   rem_q [STAGES];
    logic [WIDTH:0]   rem_d [STAGES];
    logic [WIDTH-1:0] dvd_q [STAGES];
    logic [WIDTH-1:0] dvd_d [STAGES];
    logic [WIDTH-1:0] dvs_q [STAGES];
    logic [WIDTH-1:0] dvs_d [STAGES];
    logic [WIDTH-1:0] quo_q [STAGES];
    logic [WIDTH-1:0] quo_d [STAGES];
    div_flags_t       flg_q [STAGES];
    div_flags_t       flg_d [STAGES];

    logic [WIDTH:0]   rem_nxt [STAGES];
    logic [WIDTH-1:0] dvd_nxt [STAGES];
    logic [WIDTH-1:0] quo_nxt [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
    logic             out_dbz_q, out_dbz_d;

    logic             stall;
    logic             a_neg, b_neg, dbz_in;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_mag, quo_fix, rem_fix;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        div_stage #(
            .WIDTH          (WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE)
        ) u_stage (
            .rem_i (rem_q[s]),
            .dvd_i (dvd_q[s]),
            .dvs_i (dvs_q[s]),
            .quo_i (quo_q[s]),
            .rem_o (rem_nxt[s]),
            .dvd_o (dvd_nxt[s]),
            .quo_o (quo_nxt[s])
        );
    end

    // All dividend bits are consumed by the final stage.
    logic dvd_unused;
    assign dvd_unused = ^dvd_nxt[LAST];

`ifndef DIVIDER_SIGNED_EN
    logic sign_unused;
    assign sign_unused = in_signed ^ flg_q[LAST].neg_q ^ flg_q[LAST].neg_r;
`endif

    always_comb begin
        stall = out_valid_q && !out_ready;

        for (int s = 0; s < STAGES; s++) begin
            rem_d[s] = rem_q[s];
            dvd_d[s] = dvd_q[s];
            dvs_d[s] = dvs_q[s];
            quo_d[s] = quo_q[s];
            flg_d[s] = flg_q[s];
        end
        out_valid_d     = out_valid_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_dbz_d       = out_dbz_q;

        dbz_in = (in_divisor == '0);
`ifdef DIVIDER_SIGNED_EN
        a_neg   = div_operand_neg(in_signed, in_dividend[WIDTH-1]);
        b_neg   = div_operand_neg(in_signed, in_divisor[WIDTH-1]);
        dvd_mag = a_neg ? -in_dividend : in_dividend;
        dvs_mag = b_neg ? -in_divisor  : in_divisor;
`else
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        dvd_mag = in_dividend;
        dvs_mag = in_divisor;
`endif

        rem_mag = rem_nxt[LAST][WIDTH-1:0] + (rem_nxt[LAST][WIDTH] ? dvs_q[LAST] : '0);
        quo_fix = quo_nxt[LAST];
        rem_fix = rem_mag;
`ifdef DIVIDER_SIGNED_EN
        if (flg_q[LAST].neg_q) quo_fix = -quo_fix;
        if (flg_q[LAST].neg_r) rem_fix = -rem_fix;
`endif
        // On divide by zero the divisor slot carries the raw dividend (see stage 0)
        if (flg_q[LAST].dbz) begin
            quo_fix = DIV_ALL_ONES[WIDTH-1:0];
            rem_fix = dvs_q[LAST];
        end

        if (!stall) begin
            rem_d[0] = '0;
            quo_d[0] = '0;
            dvd_d[0] = dvd_mag;
            // A zero divisor needs no divisor value, so that slot keeps the dividend
            dvs_d[0] = dbz_in ? in_dividend : dvs_mag;
            flg_d[0] = '{neg_q: a_neg ^ b_neg, neg_r: a_neg, dbz: dbz_in, valid: in_valid};

            for (int s = 1; s < STAGES; s++) begin
                rem_d[s] = rem_nxt[s-1];
                dvd_d[s] = dvd_nxt[s-1];
                dvs_d[s] = dvs_q[s-1];
                quo_d[s] = quo_nxt[s-1];
                flg_d[s] = flg_q[s-1];
            end

            out_valid_d = flg_q[LAST].valid;
            if (flg_q[LAST].valid) begin
                out_quotient_d  = quo_fix;
                out_remainder_d = rem_fix;
                out_dbz_d       = flg_q[LAST].dbz;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                rem_q[s] <= '0;
                dvd_q[s] <= '0;
                dvs_q[s] <= '0;
                quo_q[s] <= '0;
                flg_q[s] <= '0;
            end
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_dbz_q       <= 1'b0;
        end else begin
            rem_q           <= rem_d;
            dvd_q           <= dvd_d;
            dvs_q           <= dvs_d;
            quo_q           <= quo_d;
            flg_q           <= flg_d;
            out_valid_q     <= out_valid_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_dbz_q       <= out_dbz_d;
        end
    end

    assign in_ready        = !stall;
    assign out_valid       = out_valid_q;
    assign out_quotient    = out_quotient_q;
    assign out_remainder   = out_remainder_q;
    assign out_div_by_zero = out_dbz_q;

endmodule

// File: tb/tb_divider_pipe_n.sv
// Directed bench for divider_pipe_n at WIDTH=32, BITS_PER_STAGE=8 (4 stages).
module tb_divider_pipe_n;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    divider_pipe_n #(
        .WIDTH          (WIDTH),
        .BITS_PER_STAGE (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_signed       (in_signed),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_div_by_zero (out_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single divide on an idle pipeline; operands are withdrawn right after accept.
    task automatic run_op(input string name, input logic [31:0] d, input logic [31:0] v,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz);
        in_valid    = 1'b1;
        in_dividend = d;
        in_divisor  = v;
        in_signed   = sgn;
        chk({name, ":in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_signed   = 1'b0;
        repeat (STAGES - 1) @(posedge clk);
        #1;
        chk({name, ":early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, ":valid"}, 32'(out_valid), 32'd1);
        chk({name, ":q"}, out_quotient, eq);
        chk({name, ":r"}, out_remainder, er);
        chk({name, ":dbz"}, 32'(out_div_by_zero), 32'(edbz));
        @(posedge clk); #1;
    endtask

    logic [31:0] s_dvd [6] = '{32'd100, 32'hFFFF_FFFF, 32'd1000, 32'd5, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] s_dvs [6] = '{32'd7,   32'h10,        32'd1000, 32'd9, 32'h100,       32'd3};
    logic [31:0] s_q   [6] = '{32'd14,  32'h0FFF_FFFF, 32'd1,    32'd0, 32'h0012_3456, 32'h2AAA_AAAA};
    logic [31:0] s_r   [6] = '{32'd2,   32'hF,         32'd0,    32'd5, 32'h78,        32'd2};

    initial begin
        int idx;
        int ridx;
        int stale;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:q", out_quotient, 32'd0);
        chk("rst:r", out_remainder, 32'd0);
        chk("rst:dbz", 32'(out_div_by_zero), 32'd0);
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("u_1e_4", 32'h1E, 32'h4, 1'b0, 32'h7, 32'h2, 1'b0);
        run_op("u_dbz", 32'h0A, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_000A, 1'b1);
        run_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
        run_op("u_max_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifdef DIVIDER_SIGNED_EN
        run_op("s_m500_3", 32'hFFFF_FE0C, 32'h3, 1'b1, 32'hFFFF_FF5A, 32'hFFFF_FFFE, 1'b0);
        run_op("s_10_m3", 32'h0A, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b0);
        run_op("s_m100_m9", 32'hFFFF_FF9C, 32'hFFFF_FFF7, 1'b1, 32'hB, 32'hFFFF_FFFF, 1'b0);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
        run_op("s_dbz", 32'hFFFF_FFF0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
`else
        run_op("nosign_m4_2", 32'hFFFF_FFFC, 32'h2, 1'b1, 32'h7FFF_FFFE, 32'h0, 1'b0);
`endif

        // Back-to-back stream with out_ready dropped for three cycles mid-stream.
        idx  = 0;
        ridx = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready   = !(c >= 5 && c <= 7);
            in_valid    = (idx < 6);
            in_dividend = (idx < 6) ? s_dvd[idx] : '0;
            in_divisor  = (idx < 6) ? s_dvs[idx] : '0;
            in_signed   = 1'b0;
            @(negedge clk);
            if (out_valid && !out_ready)
                chk("stream:in_ready_stall", 32'(in_ready), 32'd0);
            if (in_valid && in_ready)
                idx++;
            if (out_valid && out_ready) begin
                if (ridx < 6) begin
                    chk($sformatf("stream:q%0d", ridx), out_quotient, s_q[ridx]);
                    chk($sformatf("stream:r%0d", ridx), out_remainder, s_r[ridx]);
                end else begin
                    chk("stream:extra_result", 32'(ridx), 32'd5);
                end
                ridx++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream:accepted", 32'(idx), 32'd6);
        chk("stream:retired", 32'(ridx), 32'd6);

        // Reset with one result presented and two divides still in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            in_dividend = 32'd9 + 32'(i);
            in_divisor  = 32'd3;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid:valid_before", 32'(out_valid), 32'd1);
        chk("rstmid:q_before", out_quotient, 32'd3);
        reset = 1'b1;
        #1;
        chk("rstmid:valid", 32'(out_valid), 32'd0);
        chk("rstmid:q", out_quotient, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("rstmid:no_stale", 32'(stale), 32'd0);

        run_op("u_after_rst", 32'd50, 32'd7, 1'b0, 32'd7, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
